// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: bundle between the value-producing logic (master) and
// the 7-segment scan controller (slave). The master supplies the digit word
// and control strobes; the slave returns the display-side outputs.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [IW-1:0]           digit_idx;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in,
        input  bcd_out, an_n, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, digits_in,
        output bcd_out, an_n, digit_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment
// digits sharing one BCD decoder. Double-buffered digit word, blanking gap
// before every digit, registered outputs only.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to suppress leading
// zeros (digit 0 is always shown; suppressed digits keep their time slot).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_ctrl_if.slave     bus
);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] pending_reg;
    logic [4*NUM_DIGITS-1:0] active_reg;
    logic [3:0]              bcd_reg;
    logic [NUM_DIGITS-1:0]   an_n_reg;
    logic                    frame_done_reg;

    // Per-digit view of the active buffer so the selected digit is a plain mux.
    logic [3:0] act_dig [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign act_dig[gi] = active_reg[4*gi +: 4];
        end
    endgenerate

    // A load coinciding with the digit-0 BLANK entry wins over the old pending word.
    logic [4*NUM_DIGITS-1:0] copy_val;
    assign copy_val = bus.load ? bus.digits_in : pending_reg;

    logic suppress;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // zero_from[k]: active digits k..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] zero_from;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (act_dig[gi] == 4'h0);
            end else begin : g_rest
                assign zero_from[gi] = zero_from[gi+1] & (act_dig[gi] == 4'h0);
            end
        end
    endgenerate
    assign suppress = (idx_reg != '0) && zero_from[idx_reg];
`else
    assign suppress = 1'b0;
`endif

    // Values loaded into the output registers when a digit becomes lit.
    logic [3:0]            show_bcd;
    logic [NUM_DIGITS-1:0] show_an;
    assign show_bcd = suppress ? 4'hF : act_dig[idx_reg];
    assign show_an  = suppress ? '1 : ~(NUM_DIGITS'(1) << idx_reg);

    // Scan FSM with buffers and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pending_reg    <= '0;
            active_reg     <= '0;
            bcd_reg        <= 4'hF;
            an_n_reg       <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (bus.load) begin
                pending_reg <= bus.digits_in;
            end
            if (!bus.enable) begin
                // Abandon the scan entirely; the next enable starts a fresh frame.
                state_reg <= IDLE;
                cnt_reg   <= '0;
                idx_reg   <= '0;
                bcd_reg   <= 4'hF;
                an_n_reg  <= '1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg  <= BLANK;
                        cnt_reg    <= '0;
                        idx_reg    <= '0;
                        active_reg <= copy_val;
                    end
                    BLANK: begin
                        if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
                            state_reg <= SHOW;
                            cnt_reg   <= '0;
                            bcd_reg   <= show_bcd;
                            an_n_reg  <= show_an;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    SHOW: begin
                        if (cnt_reg == CW'(REFRESH_DIV - 1)) begin
                            state_reg <= BLANK;
                            cnt_reg   <= '0;
                            bcd_reg   <= 4'hF;
                            an_n_reg  <= '1;
                            if (idx_reg == IW'(NUM_DIGITS - 1)) begin
                                idx_reg        <= '0;
                                frame_done_reg <= 1'b1;
                                active_reg     <= copy_val;
                            end else begin
                                idx_reg <= idx_reg + IW'(1);
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        bcd_reg   <= 4'hF;
                        an_n_reg  <= '1;
                    end
                endcase
            end
        end
    end

    assign bus.bcd_out    = bcd_reg;
    assign bus.an_n       = an_n_reg;
    assign bus.digit_idx  = idx_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=4, BLANK_CYCLES=2. Expected per-cycle outputs are queued when
// a frame is started and compared one cycle at a time.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;
    localparam int SLOT  = BC + RD;
    localparam int FRAME = ND * SLOT;

    logic clk;
    logic rst_n;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock edge, then compare against the oldest queued expectation.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("an_n",       32'(bus.an_n),       32'(e.an));
            chk("bcd_out",    32'(bus.bcd_out),    32'(e.bcd));
            chk("digit_idx",  32'(bus.digit_idx),  32'(e.idx));
            chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.an  = '1;
        e.bcd = 4'hF;
        e.idx = '0;
        e.fd  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push_idle();
            cyc();
        end
    endtask

    // Expected outputs for the first n cycles of a frame showing v.
    task automatic push_frame(input logic [15:0] v, input bit first, input int n);
        exp_t e;
        int   k;
        bit   blank;
        k = 0;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < SLOT; c++) begin
                e.an  = '1;
                e.bcd = 4'hF;
                e.idx = 2'(d);
                e.fd  = (d == 0 && c == 0 && !first);
                if (c >= BC) begin
                    blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    blank = (d >= 1) && ((v >> (4 * d)) == 16'h0);
`endif
                    if (!blank) begin
                        e.an  = ~(4'b0001 << d);
                        e.bcd = v[4*d +: 4];
                    end
                end
                if (k < n) exp_q.push_back(e);
                k++;
            end
        end
    endtask

    // Run n cycles of a frame expected to show v; optionally pulse load
    // before cycle load_at (0 = the edge entering BLANK of digit 0).
    task automatic run_frame(input logic [15:0] v, input bit first, input int n,
                             input int load_at, input logic [15:0] load_val);
        push_frame(v, first, n);
        $display("frame value=%h first=%0d cycles=%0d load_at=%0d load_val=%h",
                 v, first, n, load_at, load_val);
        for (int k = 0; k < n; k++) begin
            if (k == load_at) begin
                bus.load      = 1'b1;
                bus.digits_in = load_val;
            end
            cyc();
            bus.load = 1'b0;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an_n",       32'(bus.an_n),       32'hF);
        chk("rst_bcd_out",    32'(bus.bcd_out),    32'hF);
        chk("rst_digit_idx",  32'(bus.digit_idx),  32'h0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic scan with a load coinciding with the IDLE->BLANK entry.
        bus.enable = 1'b1;
        run_frame(16'h1234, 1'b1, FRAME, 0, 16'h1234);
        // Load mid-frame (SHOW of digit 2): current frame unchanged.
        run_frame(16'h1234, 1'b0, FRAME, 15, 16'h5678);
        run_frame(16'h5678, 1'b0, FRAME, -1, 16'h0);

        // Drop enable during SHOW of digit 1, then restart.
        run_frame(16'h5678, 1'b0, 10, -1, 16'h0);
        bus.enable = 1'b0;
        idle_cycles(3);
        bus.enable = 1'b1;
        run_frame(16'h5678, 1'b1, FRAME, -1, 16'h0);

        // Asynchronous reset mid-SHOW wipes the pending load as well.
        run_frame(16'h5678, 1'b0, 12, 3, 16'h0042);
        rst_n = 1'b0;
        #1;
        chk("arst_an_n",       32'(bus.an_n),       32'hF);
        chk("arst_bcd_out",    32'(bus.bcd_out),    32'hF);
        chk("arst_digit_idx",  32'(bus.digit_idx),  32'h0);
        chk("arst_frame_done", 32'(bus.frame_done), 32'h0);
        idle_cycles(2);
        rst_n = 1'b1;
        run_frame(16'h0000, 1'b1, FRAME, -1, 16'h0);

        // Leading-zero patterns.
        run_frame(16'h0000, 1'b0, FRAME, 5, 16'h0042);
        run_frame(16'h0042, 1'b0, FRAME, 7, 16'h0000);
        run_frame(16'h0000, 1'b0, FRAME, -1, 16'h0);

        // Load exactly on the digit-0 BLANK entry shows in that frame.
        run_frame(16'h9999, 1'b0, FRAME, 0, 16'h9999);
        // Invalid nibbles pass through unchanged.
        run_frame(16'h9999, 1'b0, FRAME, 20, 16'hA0F3);
        run_frame(16'hA0F3, 1'b0, FRAME, -1, 16'h0);

        if (exp_q.size() != 0) begin
            chk("queue_drained", 32'(exp_q.size()), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
